// File: rtl/memory_game_pkg.sv
// Shared constants and types for the Memory Game datapath blocks.
package memory_game_pkg;

  // Default table geometry
  localparam int DEF_TIME_W  = 15;
  localparam int DEF_ENTRIES = 3;

  // BCD field positions inside a time word; field order matches numeric order
  localparam int SEC_DOZ_MSB = 14;
  localparam int SEC_DOZ_LSB = 12;
  localparam int SEC_UNI_MSB = 11;
  localparam int SEC_UNI_LSB = 8;
  localparam int HUN_DOZ_MSB = 7;
  localparam int HUN_DOZ_LSB = 4;
  localparam int HUN_UNI_MSB = 3;
  localparam int HUN_UNI_LSB = 0;

  // Insertion sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    SHIFT = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } hs_state_e;

endpackage

// File: rtl/highscore_table_ctrl_if.sv
// Bus between the game logic / text screen and the highscore table.
interface highscore_table_ctrl_if
  import memory_game_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int TIME_W  = DEF_TIME_W
) ();

  logic                           new_score_valid;
  logic [TIME_W-1:0]              new_score_time;
  logic                           clear_table;
  logic [$clog2(ENTRIES)-1:0]     rd_idx;
  logic [TIME_W-1:0]              rd_time;
  logic                           rd_occupied;
  logic                           busy;
  logic                           done;
  logic [$clog2(ENTRIES+1)-1:0]   inserted_rank;

  // Game logic and screen side
  modport master (
    output new_score_valid, new_score_time, clear_table, rd_idx,
    input  rd_time, rd_occupied, busy, done, inserted_rank
  );

  // Table controller side
  modport slave (
    input  new_score_valid, new_score_time, clear_table, rd_idx,
    output rd_time, rd_occupied, busy, done, inserted_rank
  );

endinterface

// File: rtl/bcd_time_less.sv
// Strict a < b on BCD time words; an absent b counts as infinitely slow.
module bcd_time_less
  import memory_game_pkg::*;
#(
  parameter int TIME_W = DEF_TIME_W
) (
  input  logic [TIME_W-1:0] a,
  input  logic [TIME_W-1:0] b,
  input  logic              b_valid,
  output logic              lt
);

  // BCD digits sit in descending significance, so a binary compare is numeric
  always_comb begin
    lt = 1'b0;
    if (!b_valid) begin
      lt = 1'b1;
    end else begin
      lt = (a < b);
    end
  end

endmodule

// File: rtl/highscore_table_ctrl.sv
// Ranked top-N best-time table with a one-entry-per-clock insertion sequencer.
module highscore_table_ctrl
  import memory_game_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int TIME_W  = DEF_TIME_W
) (
  input logic                   clk,
  input logic                   rst_n,
  highscore_table_ctrl_if.slave bus
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int RANK_W = $clog2(ENTRIES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  hs_state_e          state_r;
  logic [TIME_W-1:0]  entry_time_r [ENTRIES];
  logic [ENTRIES-1:0] entry_occ_r;
  logic [TIME_W-1:0]  new_time_r;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   pos_r;
  logic               busy_r;
  logic               done_r;
  logic [RANK_W-1:0]  rank_r;
  logic [TIME_W-1:0]  rd_time_r;
  logic               rd_occ_r;
  logic               hit_s;
  logic               rd_in_range_s;

  // The new time ranks above the entry currently being scanned
  bcd_time_less #(.TIME_W(TIME_W)) u_less (
    .a       (new_time_r),
    .b       (entry_time_r[idx_r]),
    .b_valid (entry_occ_r[idx_r]),
    .lt      (hit_s)
  );

  assign rd_in_range_s = (int'(bus.rd_idx) < ENTRIES);

  // Insertion sequencer: scan for the rank, ripple worse entries down, write the new time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      entry_occ_r <= '0;
      for (int k = 0; k < ENTRIES; k++) begin
        entry_time_r[k] <= '0;
      end
      new_time_r  <= '0;
      idx_r       <= '0;
      pos_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rank_r      <= '0;
    end else if (bus.clear_table) begin
      // Clearing abandons any insertion silently; the last rank stays visible
      entry_occ_r <= '0;
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.new_score_valid) begin
            new_time_r <= bus.new_score_time;
            idx_r      <= '0;
            busy_r     <= 1'b1;
            state_r    <= SCAN;
          end else begin
            busy_r <= 1'b0;
          end
        end
        SCAN: begin
          if (hit_s) begin
            pos_r <= idx_r;
            if (idx_r == LAST_IDX) begin
              state_r <= WRITE;
            end else begin
              idx_r   <= LAST_IDX;
              state_r <= SHIFT;
            end
          end else if (idx_r == LAST_IDX) begin
            rank_r  <= '0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1'b1);
          end
        end
        SHIFT: begin
          // The bottom entry is overwritten first, so the worst time falls off
          entry_time_r[idx_r] <= entry_time_r[idx_r - IDX_W'(1'b1)];
          entry_occ_r[idx_r]  <= entry_occ_r[idx_r - IDX_W'(1'b1)];
          if (idx_r == pos_r + IDX_W'(1'b1)) begin
            state_r <= WRITE;
          end else begin
            idx_r <= idx_r - IDX_W'(1'b1);
          end
        end
        WRITE: begin
          entry_time_r[pos_r] <= new_time_r;
          entry_occ_r[pos_r]  <= 1'b1;
          rank_r              <= RANK_W'(pos_r) + RANK_W'(1'b1);
          done_r              <= 1'b1;
          state_r             <= DONE;
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Registered read port; empty or out-of-range slots read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_time_r <= '0;
      rd_occ_r  <= 1'b0;
    end else if (rd_in_range_s && entry_occ_r[bus.rd_idx]) begin
      rd_time_r <= entry_time_r[bus.rd_idx];
      rd_occ_r  <= 1'b1;
    end else begin
      rd_time_r <= '0;
      rd_occ_r  <= 1'b0;
    end
  end

  assign bus.rd_time       = rd_time_r;
  assign bus.rd_occupied   = rd_occ_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.inserted_rank = rank_r;

endmodule

// File: tb/tb_highscore_table_ctrl.sv
// Directed bench for highscore_table_ctrl with a done/rank scoreboard.
module tb_highscore_table_ctrl;

  localparam int ENTRIES = 3;
  localparam int TIME_W  = 15;

  typedef struct {
    int rank;
    int cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  exp_t exp_q[$];

  highscore_table_ctrl_if #(.ENTRIES(ENTRIES), .TIME_W(TIME_W)) bus_if ();

  highscore_table_ctrl #(.ENTRIES(ENTRIES), .TIME_W(TIME_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Edge counter used to time done pulses
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [14:0] bcd(input int sd, input int su, input int hd, input int hu);
    logic [31:0] a, b, c, d;
    a = sd; b = su; c = hd; d = hu;
    return {a[2:0], b[3:0], c[3:0], d[3:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected insertion
  always @(negedge clk) begin
    if (rst_n && bus_if.done) begin
      chk("done_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("inserted_rank", 32'(bus_if.inserted_rank), e.rank);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic start_insert(input logic [14:0] t, input int rank, input bit track);
    @(negedge clk);
    bus_if.new_score_time  = t;
    bus_if.new_score_valid = 1'b1;
    if (track) begin
      exp_q.push_back('{rank, cyc + 1 + ENTRIES + ((rank > 0) ? 1 : 0)});
    end
    @(posedge clk);
    #1;
    bus_if.new_score_valid = 1'b0;
    chk("busy_after_accept", 32'(bus_if.busy), 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (bus_if.busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", 32'(bus_if.busy), 32'd0);
  endtask

  task automatic insert(input logic [14:0] t, input int rank);
    start_insert(t, rank, 1'b1);
    wait_idle();
  endtask

  task automatic read_chk(input int idx, input logic occ, input logic [14:0] t);
    logic [31:0] i;
    i = idx;
    @(negedge clk);
    bus_if.rd_idx = i[1:0];
    @(posedge clk);
    #1;
    chk("rd_occupied", 32'(bus_if.rd_occupied), 32'(occ));
    chk("rd_time", 32'(bus_if.rd_time), 32'(t));
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus_if.clear_table = 1'b1;
    @(negedge clk);
    bus_if.clear_table = 1'b0;
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence
  initial begin
    bus_if.new_score_valid = 1'b0;
    bus_if.new_score_time  = '0;
    bus_if.clear_table     = 1'b0;
    bus_if.rd_idx          = '0;
    #1;
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_done", 32'(bus_if.done), 32'd0);
    chk("rst_rank", 32'(bus_if.inserted_rank), 32'd0);
    chk("rst_rd_time", 32'(bus_if.rd_time), 32'd0);
    chk("rst_rd_occ", 32'(bus_if.rd_occupied), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Empty table, first score lands at rank 1
    insert(bcd(1, 2, 3, 4), 1);
    read_chk(0, 1'b1, bcd(1, 2, 3, 4));
    read_chk(1, 1'b0, 15'd0);

    // Clear, then build {10.00, 20.00, 30.00}
    do_clear();
    read_chk(0, 1'b0, 15'd0);
    insert(bcd(2, 0, 0, 0), 1);
    insert(bcd(1, 0, 0, 0), 1);
    insert(bcd(3, 0, 0, 0), 3);

    // Middle insertion pushes 30.00 out
    insert(bcd(1, 5, 5, 0), 2);
    read_chk(0, 1'b1, bcd(1, 0, 0, 0));
    read_chk(1, 1'b1, bcd(1, 5, 5, 0));
    read_chk(2, 1'b1, bcd(2, 0, 0, 0));

    // Too slow for a full table: not placed, table untouched
    insert(bcd(4, 5, 0, 0), 0);
    read_chk(0, 1'b1, bcd(1, 0, 0, 0));
    read_chk(1, 1'b1, bcd(1, 5, 5, 0));
    read_chk(2, 1'b1, bcd(2, 0, 0, 0));

    // Tie goes below the existing entry
    do_clear();
    insert(bcd(1, 0, 0, 0), 1);
    insert(bcd(2, 0, 0, 0), 2);
    insert(bcd(2, 0, 0, 0), 3);
    read_chk(1, 1'b1, bcd(2, 0, 0, 0));
    read_chk(2, 1'b1, bcd(2, 0, 0, 0));

    // Pulse while busy is dropped; only one done may appear
    do_clear();
    start_insert(bcd(3, 0, 0, 0), 1, 1'b1);
    @(negedge clk);
    bus_if.new_score_time  = bcd(0, 5, 0, 0);
    bus_if.new_score_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.new_score_valid = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    read_chk(0, 1'b1, bcd(3, 0, 0, 0));
    read_chk(1, 1'b0, 15'd0);

    // Clear in the middle of a shift
    do_clear();
    insert(bcd(1, 0, 0, 0), 1);
    insert(bcd(2, 0, 0, 0), 2);
    insert(bcd(3, 0, 0, 0), 3);
    start_insert(bcd(0, 5, 0, 0), 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus_if.clear_table = 1'b1;
    @(posedge clk);
    #1;
    chk("clear_busy", 32'(bus_if.busy), 32'd0);
    chk("clear_done", 32'(bus_if.done), 32'd0);
    @(negedge clk);
    bus_if.clear_table = 1'b0;
    chk("clear_rank_held", 32'(bus_if.inserted_rank), 32'd3);
    repeat (8) @(negedge clk);
    read_chk(0, 1'b0, 15'd0);
    read_chk(1, 1'b0, 15'd0);
    read_chk(2, 1'b0, 15'd0);

    // Reset in the middle of an insertion
    insert(bcd(1, 0, 0, 0), 1);
    start_insert(bcd(0, 5, 0, 0), 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    chk("mid_rst_done", 32'(bus_if.done), 32'd0);
    chk("mid_rst_rank", 32'(bus_if.inserted_rank), 32'd0);
    chk("mid_rst_rd_occ", 32'(bus_if.rd_occupied), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    read_chk(0, 1'b0, 15'd0);
    read_chk(1, 1'b0, 15'd0);
    read_chk(2, 1'b0, 15'd0);

    repeat (4) @(negedge clk);
    chk("pending_done", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
